// File: rtl/dram_cmd_responder.sv
// Device-side DRAM command responder: decodes commands, tracks one open row, returns reads, flags violations.
// Latency: read data appears (VALID=1) exactly T_CL cycles after the READ command edge.
// Backpressure: none; every legal command is accepted and reads may issue every cycle.
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   CSn/RASn/CASn/WEn   : command strobes (WEn doubles as active-low byte enables on WRITE)
//   A, D                : row/column address and write data
//   Q, VALID            : read data and its one-cycle qualifier (Q holds between pulses)
//   err, err_code       : sticky violation flag and code of the first violation since reset
module dram_cmd_responder #(
    parameter int ROW_BITS = 6,
    parameter int COL_BITS = 6,
    parameter int T_RCD    = 5,
    parameter int T_RP     = 5,
    parameter int T_CL     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CSn,
    input  logic        RASn,
    input  logic        CASn,
    input  logic [3:0]  WEn,
    input  logic [10:0] A,
    input  logic [31:0] D,
    output logic [31:0] Q,
    output logic        VALID,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int AW = ROW_BITS + COL_BITS;

    localparam logic [0:0] ST_CLOSED = 1'b0;
    localparam logic [0:0] ST_OPEN   = 1'b1;

    localparam logic [15:0] RCD_SAT = 16'(T_RCD);
    localparam logic [15:0] RP_SAT  = 16'(T_RP);

    localparam logic [2:0] E_NONE      = 3'd0;
    localparam logic [2:0] E_ACT_OPEN  = 3'd1;
    localparam logic [2:0] E_ACT_TRP   = 3'd2;
    localparam logic [2:0] E_RW_CLOSED = 3'd3;
    localparam logic [2:0] E_RW_TRCD   = 3'd4;
    localparam logic [2:0] E_PRE_CLOSE = 3'd5;
    localparam logic [2:0] E_ILLEGAL   = 3'd6;

    logic [0:0]          state;
    logic [ROW_BITS-1:0] row;
    logic [15:0]         rcd_cnt;   // cycles since last accepted ACT, saturating
    logic [15:0]         rp_cnt;    // cycles since last accepted PRE, saturating
    logic                rcd_ok;
    logic                rp_ok;

    logic                do_act;
    logic                do_pre;
    logic                do_rd;
    logic                do_wr;
    logic [2:0]          viol;

    logic [31:0]         mem [0:(1 << AW) - 1];
    logic [AW-1:0]       mem_addr;
    logic [31:0]         rd_word;

    logic [T_CL-1:0]     vld_pipe;
    logic [31:0]         dat_pipe [T_CL];

    // Upper address bits beyond the indexed range are intentionally ignored.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^A;

    assign rcd_ok   = (rcd_cnt >= RCD_SAT);
    assign rp_ok    = (rp_cnt >= RP_SAT);
    assign mem_addr = {row, A[COL_BITS-1:0]};
    assign rd_word  = mem[mem_addr];

    // Command decode and legality check. Conditions are tested in code
    // order so that the lowest applicable code is reported.
    always_comb begin
        do_act = 1'b0;
        do_pre = 1'b0;
        do_rd  = 1'b0;
        do_wr  = 1'b0;
        viol   = E_NONE;
        if (!CSn) begin
            if (!RASn && CASn && (WEn == 4'hF)) begin
                if (state == ST_OPEN)  viol = E_ACT_OPEN;
                else if (!rp_ok)       viol = E_ACT_TRP;
                else                   do_act = 1'b1;
            end else if (!RASn && CASn && (WEn == 4'h0)) begin
                if (state == ST_CLOSED) viol = E_PRE_CLOSE;
                else                    do_pre = 1'b1;
            end else if (RASn && !CASn) begin
                if (state == ST_CLOSED) viol = E_RW_CLOSED;
                else if (!rcd_ok)       viol = E_RW_TRCD;
                else if (WEn == 4'hF)   do_rd = 1'b1;
                else                    do_wr = 1'b1;
            end else begin
                viol = E_ILLEGAL;
            end
        end
    end

    // Row state and timing counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLOSED;
            row     <= '0;
            rcd_cnt <= '0;
            rp_cnt  <= RP_SAT;   // first ACT after reset is always legal
        end else begin
            if (do_act) begin
                state   <= ST_OPEN;
                row     <= A[ROW_BITS-1:0];
                rcd_cnt <= 16'd1;
            end else if (rcd_cnt < RCD_SAT) begin
                rcd_cnt <= rcd_cnt + 16'd1;
            end

            if (do_pre) begin
                state  <= ST_CLOSED;
                rp_cnt <= 16'd1;
            end else if (rp_cnt < RP_SAT) begin
                rp_cnt <= rp_cnt + 16'd1;
            end
        end
    end

    // Storage survives reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (!rst && do_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (!WEn[i]) mem[mem_addr][8*i +: 8] <= D[8*i +: 8];
            end
        end
    end

    // Read data path: no reset needed, qualified by vld_pipe.
    always_ff @(posedge clk) begin
        dat_pipe[0] <= rd_word;
        for (int i = 1; i < T_CL; i++) dat_pipe[i] <= dat_pipe[i-1];
    end

    // The extra output register makes VALID land exactly T_CL edges after
    // the READ edge while Q keeps the last returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            VALID    <= 1'b0;
            Q        <= '0;
        end else begin
            vld_pipe[0] <= do_rd;
            for (int i = 1; i < T_CL; i++) vld_pipe[i] <= vld_pipe[i-1];
            VALID <= vld_pipe[T_CL-1];
            if (vld_pipe[T_CL-1]) Q <= dat_pipe[T_CL-1];
        end
    end

    // Sticky error; only the first violation's code is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_code <= E_NONE;
        end else if (!err && (viol != E_NONE)) begin
            err      <= 1'b1;
            err_code <= viol;
        end
    end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Self-checking bench for dram_cmd_responder with a read-data scoreboard.
// Latency: checks that each VALID arrives exactly T_CL cycles after its READ.
// Backpressure: not applicable; the responder never stalls.
module tb_dram_cmd_responder;

    localparam int ROW_BITS = 6;
    localparam int COL_BITS = 6;
    localparam int T_RCD    = 5;
    localparam int T_RP     = 5;
    localparam int T_CL     = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CSn = 1'b1;
    logic        RASn = 1'b1;
    logic        CASn = 1'b1;
    logic [3:0]  WEn = 4'hF;
    logic [10:0] A = '0;
    logic [31:0] D = '0;
    logic [31:0] Q;
    logic        VALID;
    logic        err;
    logic [2:0]  err_code;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] tb_mem [4096];
    logic [5:0]  cur_row = '0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    dram_cmd_responder #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL)
    ) dut (
        .clk(clk), .rst(rst), .CSn(CSn), .RASn(RASn), .CASn(CASn),
        .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard: every VALID must match the oldest outstanding read, on time.
    always @(negedge clk) begin
        if (VALID === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", Q, e.dat);
                check("rd_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // Inputs change just after a negedge; the following posedge samples them.
    task automatic cmd(input logic cs, input logic ras, input logic cas,
                       input logic [3:0] we, input logic [10:0] a, input logic [31:0] d);
        CSn = cs; RASn = ras; CASn = cas; WEn = we; A = a; D = d;
        @(negedge clk);
        CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF;
    endtask

    task automatic nop(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic act(input logic [5:0] r);
        cur_row = r;
        cmd(1'b0, 1'b0, 1'b1, 4'hF, {5'd0, r}, 32'd0);
    endtask

    task automatic pre();
        cmd(1'b0, 1'b0, 1'b1, 4'h0, 11'd0, 32'd0);
    endtask

    task automatic wr(input logic [5:0] col, input logic [31:0] d, input logic [3:0] we);
        logic [11:0] idx;
        idx = {cur_row, col};
        for (int i = 0; i < 4; i++)
            if (!we[i]) tb_mem[idx][8*i +: 8] = d[8*i +: 8];
        cmd(1'b0, 1'b1, 1'b0, we, {5'd0, col}, d);
    endtask

    // Legal read: expected word and arrival cycle go on the scoreboard.
    task automatic rd(input logic [5:0] col);
        exp_t e;
        e.dat = tb_mem[{cur_row, col}];
        e.due = cyc + 1 + T_CL;
        sb.push_back(e);
        cmd(1'b0, 1'b1, 1'b0, 4'hF, {5'd0, col}, 32'd0);
    endtask

    // Read that must be rejected or cancelled: nothing is expected back.
    task automatic rd_bad(input logic [5:0] col);
        cmd(1'b0, 1'b1, 1'b0, 4'hF, {5'd0, col}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop(2);
        rst = 1'b0;
        check("rst_valid", {31'd0, VALID}, 32'd0);
        check("rst_q", Q, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_code", {29'd0, err_code}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Basic write/read at the tRCD boundary; read right after write.
        act(6'h03);
        nop(T_RCD - 1);
        wr(6'h05, 32'hDEADBEEF, 4'h0);
        rd(6'h05);
        nop(T_CL + 2);
        check("basic_err", {31'd0, err}, 32'd0);

        // Byte-lane merge.
        wr(6'h06, 32'h11223344, 4'h0);
        wr(6'h06, 32'hAABBCCDD, 4'b1010);
        rd(6'h06);
        nop(T_CL + 2);
        check("byte_model", tb_mem[{6'h03, 6'h06}], 32'h11BB33DD);
        check("byte_q", Q, 32'h11BB33DD);

        // Pipelined reads after PRE->ACT at exactly tRP and tRCD.
        for (int i = 0; i < 4; i++) wr(6'(i), 32'hA0 + 32'(i), 4'h0);
        pre();
        nop(T_RP - 1);
        act(6'h03);
        nop(T_RCD - 1);
        for (int i = 0; i < 4; i++) rd(6'(i));
        nop(T_CL + 2);
        check("pipe_hold_q", Q, 32'hA3);
        check("pipe_hold_valid", {31'd0, VALID}, 32'd0);
        check("pipe_err", {31'd0, err}, 32'd0);

        // Reset with a read in flight: it must never surface.
        rd_bad(6'h05);
        nop(1);
        do_reset();
        act(6'h03);
        nop(T_RCD - 1);
        rd(6'h05);
        nop(T_CL + 2);
        check("rst_mid_err", {31'd0, err}, 32'd0);
        check("rst_mid_q", Q, 32'hDEADBEEF);

        // READ too soon after ACT.
        pre();
        nop(T_RP - 1);
        act(6'h03);
        nop(2);
        rd_bad(6'h00);
        nop(T_CL + 2);
        check("trcd_err", {31'd0, err}, 32'd1);
        check("trcd_code", {29'd0, err_code}, 32'd4);

        // ACT too soon after PRE; row must stay closed, code must stay.
        do_reset();
        act(6'h03);
        pre();
        nop(1);
        act(6'h03);
        check("trp_code", {29'd0, err_code}, 32'd2);
        nop(T_RCD);
        rd_bad(6'h00);
        nop(T_CL + 2);
        check("trp_err", {31'd0, err}, 32'd1);
        check("trp_code_kept", {29'd0, err_code}, 32'd2);

        // Illegal encoding.
        do_reset();
        cmd(1'b0, 1'b0, 1'b0, 4'hF, 11'd0, 32'd0);
        check("illegal_code", {29'd0, err_code}, 32'd6);

        // PRE with no row open.
        do_reset();
        pre();
        check("pre_closed_code", {29'd0, err_code}, 32'd5);

        // ACT while open.
        do_reset();
        act(6'h01);
        act(6'h02);
        check("act_open_code", {29'd0, err_code}, 32'd1);

        // READ while closed and before tRCD: the lower code wins.
        do_reset();
        rd_bad(6'h00);
        check("rd_closed_code", {29'd0, err_code}, 32'd3);
        nop(T_CL + 2);

        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_cmd_responder.md
Name: dram_cmd_responder

Overview:
- Device-side responder for the DRAM command interface driven by the team's DRAM wrapper; the wrapper's command stream is this block's input.
- Decodes CSn/RASn/CASn/WEn commands, tracks the single open row, enforces tRCD/tRP, returns read data after tCL and flags protocol violations.
- Serves as the DRAM end in the SoC simulation top and as the checking responder in wrapper-level benches.
- Storage is a small synthesizable array indexed by truncated row/column.

Parameters:
- ROW_BITS, 6, row-address bits used for indexing (low bits of A[10:0]).
- COL_BITS, 6, column-address bits used for indexing (low bits of A[9:0]); must be ≤10.
- T_RCD, 5, minimum cycles from ACT to READ/WRITE.
- T_RP, 5, minimum cycles from PRE to next ACT.
- T_CL, 5, read latency in cycles, ≥1.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- CSn  in  1  chip select, active-low; CSn=1 means NOP.
- RASn  in  1  row strobe, active-low.
- CASn  in  1  column strobe, active-low.
- WEn  in  4  byte write enables, active-low; bit i covers D[8i+7:8i].
- A  in  11  row address (ACT) or column address in A[9:0] (READ/WRITE).
- D  in  32  write data.
- Q  out  32  read data.
- VALID  out  1  one-cycle pulse: Q carries read data this cycle.
- err  out  1  sticky protocol-violation flag.
- err_code  out  3  code of the first violation since reset.

Behaviour:
- Commands are sampled at the clock edge when CSn=0:
  - ACT: RASn=0, CASn=1, WEn=4'hF.
  - PRE: RASn=0, CASn=1, WEn=4'h0.
  - READ: RASn=1, CASn=0, WEn=4'hF.
  - WRITE: RASn=1, CASn=0, WEn≠4'hF.
  - Any other CSn=0 encoding is illegal.
- Row state FSM is CLOSED/OPEN. ACT latches row=A[ROW_BITS-1:0], CLOSED→OPEN. PRE does OPEN→CLOSED.
- Timing counters:
  - ACT at cycle t: READ/WRITE legal at cycles ≥ t+T_RCD.
  - PRE at cycle p: ACT legal at cycles ≥ p+T_RP.
  - Both counters saturate.
- WRITE: bytes with WEn[i]=0 are written into mem[{row, A[COL_BITS-1:0]}]; other bytes are preserved. Memory is updated at that edge.
- READ at cycle r:
  - Array is read at cycle r, so a WRITE at r-1 or earlier is visible.
  - Data is pushed into a T_CL-deep valid/data shift pipeline.
  - VALID=1 and Q=data exactly in cycle r+T_CL.
- Back-to-back READs every cycle are legal and produce back-to-back VALID pulses in order.
- Q holds the last returned data when VALID=0.
- Pipeline keeps draining across PRE/ACT.
- A violating command is ignored: no state, memory or pipeline change, and counters are unaffected. err is set; err_code records only the first violation.
- Error codes:
  - 1: ACT while OPEN.
  - 2: ACT before T_RP elapsed.
  - 3: READ/WRITE while CLOSED.
  - 4: READ/WRITE before T_RCD elapsed.
  - 5: PRE while CLOSED.
  - 6: illegal encoding.
- If one command meets several conditions, the lowest code wins.
- Reset (rst=1 at an edge, including mid-operation):
  - Q=0, VALID=0, err=0, err_code=0.
  - Row CLOSED, in-flight reads discarded.
  - T_RP treated as satisfied, so ACT is legal on the first edge after rst deasserts.
  - Memory contents are not cleared.
- Commands presented while rst=1 are ignored.

Test Plan:
- Basic write/read:
  - Stimulus: ACT row 0x003 at cycle 0; WRITE col 0x05, D=0xDEADBEEF, WEn=0 at cycle 5; READ col 0x05 at cycle 6.
  - Required: VALID=1 with Q=0xDEADBEEF at cycle 11; err=0.
- Byte write:
  - Stimulus: write 0x11223344 full-word; WRITE D=0xAABBCCDD with WEn=4'b1010 to the same address; READ.
  - Required: Q=0x11BB33DD.
- Timing violations:
  - Stimulus A: READ 3 cycles after ACT.
  - Required A: err=1, err_code=4, no VALID.
  - Stimulus B (after reset): PRE, then ACT 2 cycles later.
  - Required B: err_code=2, row stays CLOSED; a later READ adds no new code.
- Pipelined reads:
  - Stimulus: after T_RCD, 4 consecutive READs to cols 0–3 holding 0xA0–0xA3.
  - Required: VALID high 4 consecutive cycles starting 5 cycles after the first READ, Q=0xA0,0xA1,0xA2,0xA3.
- Reset mid-read:
  - Stimulus: assert rst 2 cycles after a READ, deassert, then ACT and READ the same address.
  - Required: no VALID for the cancelled read; ACT accepted immediately after reset; data written before reset is returned.
- Illegal/closed:
  - Stimulus A: CSn=0, RASn=0, CASn=0 from reset.
  - Required A: err_code=6.
  - Stimulus B (after reset): PRE with no row open.
  - Required B: err_code=5.
